l1_icache_blocking_fill: RTL
============================

Name: l1_icache_blocking_fill

Overview:
- Parametrised, direct-mapped, blocking L1 instruction cache for the fetch stage; successor to the fixed-width fetch-side cache wrapper.
- Serves a FETCH_WIDTH-wide bundle per cycle on hit.
- Owns a single-miss fill FSM with a ready/valid request handshake to the memory side, plus coherence invalidation.
- Sits between the fetch PC generator and the L2/memory interface.

Parameters:
- FETCH_WIDTH, 4, instructions per fetch bundle (1..8)
- INST_BITS, 32, instruction width
- PC_BITS, 64, PC width
- INDEX_BITS, 7, log2 of number of sets
- LINE_BYTES_LOG, 5, log2 of line bytes; words per line WPL = 2^(LINE_BYTES_LOG-2), WPL >= FETCH_WIDTH
- TAG_BITS, PC_BITS-INDEX_BITS-LINE_BYTES_LOG, derived

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fetchReq_i  in  1  fetch request this cycle
- pc_i  in  PC_BITS  bundle start PC, 4-byte aligned
- laneActive_i  in  FETCH_WIDTH  per-lane enable (dynamic width)
- flush_i  in  1  squash outstanding, not-yet-accepted request
- inst_o  out  FETCH_WIDTH*INST_BITS  lane i at bits [i*INST_BITS +: INST_BITS]
- instValid_o  out  FETCH_WIDTH  per-lane valid
- icMiss_o  out  1  fetch requested and not hit
- ic2memReqAddr_o  out  PC_BITS-LINE_BYTES_LOG  block address of fill request
- ic2memReqValid_o  out  1  fill request valid
- mem2icReqReady_i  in  1  memory accepts request
- mem2icRespValid_i  in  1  fill data valid
- mem2icRespAddr_i  in  PC_BITS-LINE_BYTES_LOG  block address of fill data
- mem2icData_i  in  2^LINE_BYTES_LOG*8  line data, word 0 in LSBs
- mem2icInv_i  in  1  invalidate request
- mem2icInvInd_i  in  INDEX_BITS  set to invalidate

Behaviour:
- Reset (sync): all valid bits 0, FSM IDLE, ic2memReqValid_o=0, ic2memReqAddr_o=0. Combinational outputs are 0 because no line is valid. Tag/data arrays are not reset.
- Lookup: tag, valid and data are held in flop arrays and read combinationally, so a hit returns data in the same cycle (0-cycle latency).
  - off = pc_i[LINE_BYTES_LOG-1:2]
  - hit = fetchReq_i & valid[idx] & (tag[idx]==pc tag)
  - instValid_o[i] = hit & laneActive_i[i] & (off+i < WPL). The bundle is truncated at the line boundary and never spans lines.
  - inst_o lane i = word off+i of the line when that word exists, else 0.
- icMiss_o = fetchReq_i & ~hit. It stays high on every requesting cycle until the line is present.
- FSM IDLE: on icMiss_o, latch the block address of pc_i and go to REQ.
- FSM REQ: ic2memReqValid_o=1, address held stable.
  - mem2icReqReady_i=1 → WAIT.
  - flush_i=1 without ready → IDLE, request dropped.
  - Ready and flush in the same cycle: the request counts as accepted → WAIT.
- FSM WAIT:
  - mem2icRespValid_i with mem2icRespAddr_i equal to the latched address → write data and tag, set valid, go to IDLE. The next cycle hits.
  - A response with a non-matching address is ignored.
  - flush_i in WAIT has no effect.
- Only one miss is outstanding. Misses to other lines while in REQ/WAIT assert icMiss_o but do not start a request.
- Invalidate: clears valid[mem2icInvInd_i] at the clock edge, in any state.
  - If the invalidate and a fill hit the same set in the same cycle, the invalidate wins: valid ends at 0 and the FSM still goes to IDLE.
- Fill and lookup in the same cycle: the lookup sees pre-fill array contents.
- Reset mid-miss returns to IDLE. A later response is ignored because the FSM is in IDLE.

Optional Feature:
- Macro: ICACHE_NEXT_LINE_PREFETCH_EN.
- Defined:
  - After a demand fill of block B, if block B+1 (mod 2^(PC_BITS-LINE_BYTES_LOG)) is not resident, go to PF_REQ, then PF_WAIT, using the same handshake.
  - A prefetch fill writes the line identically to a demand fill.
  - flush_i in PF_REQ aborts the prefetch.
  - A demand miss during PF_REQ/PF_WAIT waits until the FSM returns to IDLE.
- Undefined: IDLE/REQ/WAIT only; the PF states do not exist.

Decomposition:
- Package icache_fill_pkg: state enum (IDLE, REQ, WAIT, PF_REQ, PF_WAIT), block-address typedef, line typedef, WPL localparam function.
- Sub-module icache_fill_fsm: the state machine, request handshake and fill-enable generation. Arrays and lookup stay in the top module.

Test Plan:
- Reset, then fetchReq_i=1, pc_i=0x1000 → icMiss_o=1, instValid_o=0. Next cycle ic2memReqValid_o=1, ic2memReqAddr_o=0x80.
- Hold mem2icReqReady_i=0 for 3 cycles, then 1 → request address stable throughout. Response with addr 0x80 → the following cycle pc_i=0x1000 hits with instValid_o=4'b1111.
- pc_i=0x1018 (off=6, WPL=8) after the fill → instValid_o=4'b0011. With laneActive_i=4'b0001 → instValid_o=4'b0001.
- Miss to 0x2000; response with addr 0x81 → ignored, FSM stays in WAIT. Response with addr 0x100 → fill occurs.
- flush_i in REQ with ready=0 → FSM goes to IDLE, no request is issued. Invalidate of set 0 in the same cycle as the 0x80 fill → the next lookup of 0x1000 misses.
- With ICACHE_NEXT_LINE_PREFETCH_EN defined: a demand fill of 0x80 → a prefetch request to 0x81 is issued. After its response, pc_i=0x1020 hits with no miss.

Source files
------------

// File: rtl/l1_icache_blocking_fill_pkg.sv
// Shared types for the blocking-fill L1 I-cache: fill FSM states, block/line types, geometry helper.
// States PF_REQ/PF_WAIT exist only when ICACHE_NEXT_LINE_PREFETCH_EN is defined.
package icache_fill_pkg;

  localparam int unsigned DEF_PC_BITS        = 64;
  localparam int unsigned DEF_LINE_BYTES_LOG = 5;

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, PF_REQ, PF_WAIT} fillState_e;
`else
  typedef enum logic [1:0] {IDLE, REQ, WAIT} fillState_e;
`endif

  typedef logic [DEF_PC_BITS-DEF_LINE_BYTES_LOG-1:0]  blockAddr_t;
  typedef logic [(2**DEF_LINE_BYTES_LOG)*8-1:0]       line_t;

  function automatic int unsigned wordsPerLine(input int unsigned lineBytesLog);
    return 32'd1 << (lineBytesLog - 2);
  endfunction

endpackage

// File: rtl/l1_icache_blocking_fill_if.sv
// Memory-side bus of the I-cache: fill request handshake, fill response and coherence invalidate.
interface l1_icache_blocking_fill_if #(
  parameter int unsigned PC_BITS        = 64,
  parameter int unsigned LINE_BYTES_LOG = 5,
  parameter int unsigned INDEX_BITS     = 7
);
  logic [PC_BITS-LINE_BYTES_LOG-1:0]  ic2memReqAddr_o;
  logic                               ic2memReqValid_o;
  logic                               mem2icReqReady_i;
  logic                               mem2icRespValid_i;
  logic [PC_BITS-LINE_BYTES_LOG-1:0]  mem2icRespAddr_i;
  logic [(2**LINE_BYTES_LOG)*8-1:0]   mem2icData_i;
  logic                               mem2icInv_i;
  logic [INDEX_BITS-1:0]              mem2icInvInd_i;

  modport master (
    output ic2memReqAddr_o, ic2memReqValid_o,
    input  mem2icReqReady_i, mem2icRespValid_i, mem2icRespAddr_i,
    input  mem2icData_i, mem2icInv_i, mem2icInvInd_i
  );

  modport slave (
    input  ic2memReqAddr_o, ic2memReqValid_o,
    output mem2icReqReady_i, mem2icRespValid_i, mem2icRespAddr_i,
    output mem2icData_i, mem2icInv_i, mem2icInvInd_i
  );
endinterface

// File: rtl/l1_icache_blocking_fill_fsm.sv
// Single-outstanding-miss fill FSM: request handshake, response matching, fill enable.
// Next-line prefetch states are built only with ICACHE_NEXT_LINE_PREFETCH_EN.
module icache_fill_fsm
  import icache_fill_pkg::*;
#(
  parameter int unsigned BLK_BITS = 59
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                missReq,
  input  logic [BLK_BITS-1:0] missBlk,
  input  logic                flush,
  input  logic                reqReady,
  input  logic                respValid,
  input  logic [BLK_BITS-1:0] respAddr,
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
  input  logic                nextResident,
`endif
  output logic                reqValid,
  output logic [BLK_BITS-1:0] reqAddr,
  output logic                fillEn
);

  fillState_e state, stateNext;
  logic       latchMiss;
  logic       advancePf;
  logic       respMatch;

  assign respMatch = respValid & (respAddr == reqAddr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      reqAddr <= '0;
    end else begin
      state <= stateNext;
      if (latchMiss)      reqAddr <= missBlk;
      else if (advancePf) reqAddr <= reqAddr + BLK_BITS'(1);
    end
  end

  // Ready wins over flush in the request state: a same-cycle accept is final.
  always_comb begin
    stateNext = state;
    reqValid  = 1'b0;
    fillEn    = 1'b0;
    latchMiss = 1'b0;
    advancePf = 1'b0;
    case (state)
      IDLE: begin
        if (missReq) begin
          latchMiss = 1'b1;
          stateNext = REQ;
        end
      end
      REQ: begin
        reqValid = 1'b1;
        if (reqReady)   stateNext = WAIT;
        else if (flush) stateNext = IDLE;
      end
      WAIT: begin
        if (respMatch) begin
          fillEn = 1'b1;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
          advancePf = ~nextResident;
          stateNext = nextResident ? IDLE : PF_REQ;
`else
          stateNext = IDLE;
`endif
        end
      end
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
      PF_REQ: begin
        reqValid = 1'b1;
        if (reqReady)   stateNext = PF_WAIT;
        else if (flush) stateNext = IDLE;
      end
      PF_WAIT: begin
        if (respMatch) begin
          fillEn    = 1'b1;
          stateNext = IDLE;
        end
      end
`endif
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: rtl/l1_icache_blocking_fill.sv
// Direct-mapped blocking L1 I-cache with flop arrays, so a hit returns its bundle in the same cycle.
// Optional next-line prefetch: define ICACHE_NEXT_LINE_PREFETCH_EN.
module l1_icache_blocking_fill
  import icache_fill_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH    = 4,
  parameter int unsigned INST_BITS      = 32,
  parameter int unsigned PC_BITS        = 64,
  parameter int unsigned INDEX_BITS     = 7,
  parameter int unsigned LINE_BYTES_LOG = 5,
  parameter int unsigned TAG_BITS       = PC_BITS - INDEX_BITS - LINE_BYTES_LOG
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           fetchReq_i,
  input  logic [PC_BITS-1:0]             pc_i,
  input  logic [FETCH_WIDTH-1:0]         laneActive_i,
  input  logic                           flush_i,
  output logic [FETCH_WIDTH*INST_BITS-1:0] inst_o,
  output logic [FETCH_WIDTH-1:0]         instValid_o,
  output logic                           icMiss_o,
  l1_icache_blocking_fill_if.master      memBus
);

  localparam int unsigned WPL       = wordsPerLine(LINE_BYTES_LOG);
  localparam int unsigned NSETS     = 2 ** INDEX_BITS;
  localparam int unsigned BLK_BITS  = PC_BITS - LINE_BYTES_LOG;
  localparam int unsigned LINE_BITS = (2 ** LINE_BYTES_LOG) * 8;

  logic [TAG_BITS-1:0]  tagArr  [NSETS];
  logic [LINE_BITS-1:0] dataArr [NSETS];
  logic [NSETS-1:0]     validArr;

  logic [BLK_BITS-1:0]         pcBlk;
  logic [INDEX_BITS-1:0]       pcIdx;
  logic [TAG_BITS-1:0]         pcTag;
  logic [LINE_BYTES_LOG-3:0]   off;
  logic [LINE_BITS-1:0]        lineRd;
  logic                        hit;

  logic [BLK_BITS-1:0]   reqAddr;
  logic                  fillEn;
  logic [INDEX_BITS-1:0] fillIdx;
  logic [TAG_BITS-1:0]   fillTag;

  assign pcBlk  = pc_i[PC_BITS-1:LINE_BYTES_LOG];
  assign pcIdx  = pcBlk[INDEX_BITS-1:0];
  assign pcTag  = pcBlk[BLK_BITS-1:INDEX_BITS];
  assign off    = pc_i[LINE_BYTES_LOG-1:2];
  assign lineRd = dataArr[pcIdx];
  assign hit    = fetchReq_i & validArr[pcIdx] & (tagArr[pcIdx] == pcTag);
  assign icMiss_o = fetchReq_i & ~hit;

  assign fillIdx = reqAddr[INDEX_BITS-1:0];
  assign fillTag = reqAddr[BLK_BITS-1:INDEX_BITS];
  assign memBus.ic2memReqAddr_o = reqAddr;

  // Lanes past the end of the line stay invalid; a bundle never crosses lines.
  always_comb begin
    inst_o      = '0;
    instValid_o = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if (32'(off) + i < WPL) begin
        instValid_o[i] = hit & laneActive_i[i];
        if (hit) inst_o[i*INST_BITS +: INST_BITS] = lineRd[(32'(off) + i)*INST_BITS +: INST_BITS];
      end
    end
  end

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
  logic [BLK_BITS-1:0] nextBlk;
  logic                nextResident;
  assign nextBlk      = reqAddr + BLK_BITS'(1);
  assign nextResident = validArr[nextBlk[INDEX_BITS-1:0]]
                      & (tagArr[nextBlk[INDEX_BITS-1:0]] == nextBlk[BLK_BITS-1:INDEX_BITS]);
`endif

  icache_fill_fsm #(
    .BLK_BITS (BLK_BITS)
  ) fsm (
    .clk          (clk),
    .reset        (reset),
    .missReq      (icMiss_o),
    .missBlk      (pcBlk),
    .flush        (flush_i),
    .reqReady     (memBus.mem2icReqReady_i),
    .respValid    (memBus.mem2icRespValid_i),
    .respAddr     (memBus.mem2icRespAddr_i),
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    .nextResident (nextResident),
`endif
    .reqValid     (memBus.ic2memReqValid_o),
    .reqAddr      (reqAddr),
    .fillEn       (fillEn)
  );

  always_ff @(posedge clk) begin
    if (fillEn) begin
      tagArr[fillIdx]  <= fillTag;
      dataArr[fillIdx] <= memBus.mem2icData_i;
    end
  end

  // Invalidate is applied after the fill so it wins when both hit one set.
  always_ff @(posedge clk) begin
    if (reset) begin
      validArr <= '0;
    end else begin
      if (fillEn)             validArr[fillIdx] <= 1'b1;
      if (memBus.mem2icInv_i) validArr[memBus.mem2icInvInd_i] <= 1'b0;
    end
  end

  pcAligned: assert property (@(posedge clk) disable iff (reset) fetchReq_i |-> (pc_i[1:0] == 2'b00));

endmodule
